uart_receive: RTL and testbench

- Serial-to-parallel UART receiver, 8N1 frames, LSB first. Counterpart of the team's UART transmitter.
- Consumes the serial line produced by the transmit stage, whether looped back or from the off-chip peer.
- Delivers each received byte to game/control logic through a level-valid/ack handshake.
- Flags bad stop bits and bytes that arrive while the previous byte is still unread.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_receive_rx_sync.sv | 21 ++
 rtl/uart_receive.sv | 128 ++++++++++++
 tb/tb_uart_receive.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_receive_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs (serial lines, buttons); resets to 1.
module rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver with mid-bit sampling, level-valid/ack handshake,
// stop-bit framing error pulse and sticky overrun flag.
module uart_receive
  import uart_pkg::*;
#(
  parameter int unsigned clockperbit = 10,
  parameter int unsigned halfbit     = clockperbit / 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rxack,
  output logic [DATA_BITS-1:0] rxdata,
  output logic                 rxvalid,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(clockperbit);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LOAD = CW'(halfbit - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(clockperbit - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  uart_state_e          state;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;

  rx_sync u_rx_sync (
    .clock (clock),
    .reset (reset),
    .din   (rx),
    .dout  (rx_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rxdata      <= '0;
      rxvalid     <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      framing_err <= 1'b0;

      // Ack handling comes first so a byte completing in the same cycle wins.
      if (rxack) begin
        rxvalid <= 1'b0;
        overrun <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_LOAD;
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt     <= BIT_LOAD;
            bit_idx <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            cnt   <= BIT_LOAD;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            rxdata  <= shreg;
            rxvalid <= 1'b1;
            if (rxvalid && !rxack) begin
              overrun <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            framing_err <= 1'b1;
            state       <= WAIT_HIGH;
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Randomized and directed bench for uart_receive against a frame-level reference model.
module tb_uart_receive;

  localparam int unsigned CPB = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic       rxack = 1'b0;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned fe_cnt = 0;

  // Reference model state: what the consumer should see at frame boundaries.
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ovr;
  int unsigned m_fe;

  uart_receive #(.clockperbit(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .rxack       (rxack),
    .rxdata      (rxdata),
    .rxvalid     (rxvalid),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset && framing_err) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold_bit();
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    rx = 1'b0;
    hold_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold_bit();
    end
    rx = stop_b;
    hold_bit();
  endtask

  task automatic pulse_ack();
    rxack = 1'b1;
    tick();
    rxack = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_data"},  32'(rxdata),  32'(m_data));
    chk({tag, "_valid"}, 32'(rxvalid), 32'(m_valid));
    chk({tag, "_ovr"},   32'(overrun), 32'(m_ovr));
    chk({tag, "_fe"},    fe_cnt,       m_fe);
  endtask

  initial begin
    int unsigned lat;
    logic        saw_busy;
    logic [7:0]  b;
    logic        bad;
    int unsigned gap;

    // Reset with a toggling line
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      tick();
    end
    chk("rst_data",  32'(rxdata),      32'h0);
    chk("rst_valid", 32'(rxvalid),     32'h0);
    chk("rst_fe",    32'(framing_err), 32'h0);
    chk("rst_ovr",   32'(overrun),     32'h0);
    chk("rst_busy",  32'(busy),        32'h0);
    rx = 1'b1;
    reset = 1'b1;
    repeat (50) tick();
    chk("idle_busy",  32'(busy),    32'h0);
    chk("idle_valid", 32'(rxvalid), 32'h0);

    // 0xA5 with latency measured from the rx falling edge
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!rxvalid && lat < 200) begin
          tick();
          lat++;
        end
      end
    join
    chk("a5_latency", lat, 98);
    chk("a5_data", 32'(rxdata), 32'hA5);
    pulse_ack();
    chk("a5_ack_valid", 32'(rxvalid), 32'h0);

    // Back-to-back frames without ack
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    chk("b2b_data",  32'(rxdata),  32'hFF);
    chk("b2b_valid", 32'(rxvalid), 32'h1);
    chk("b2b_ovr",   32'(overrun), 32'h1);
    pulse_ack();
    chk("b2b_ack_valid", 32'(rxvalid), 32'h0);
    chk("b2b_ack_ovr",   32'(overrun), 32'h0);

    // Start-bit glitch
    repeat (5) tick();
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (3) begin
      tick();
      saw_busy |= busy;
    end
    rx = 1'b1;
    repeat (15) begin
      tick();
      saw_busy |= busy;
    end
    chk("glitch_saw_busy", 32'(saw_busy), 32'h1);
    chk("glitch_busy",     32'(busy),     32'h0);
    chk("glitch_valid",    32'(rxvalid),  32'h0);
    chk("glitch_fe",       fe_cnt,        0);

    // Framing error with the line held low for 40 cycles
    send_frame(8'h3C, 1'b0);
    repeat (30) tick();
    chk("fe_pulses", fe_cnt, 1);
    chk("fe_valid",  32'(rxvalid), 32'h0);
    chk("fe_busy",   32'(busy),    32'h1);
    rx = 1'b1;
    repeat (4) tick();
    chk("fe_release_busy", 32'(busy), 32'h0);
    send_frame(8'h12, 1'b1);
    chk("fe_next_data",  32'(rxdata),  32'h12);
    chk("fe_next_valid", 32'(rxvalid), 32'h1);

    // Randomized frames against the model
    pulse_ack();
    m_data  = 8'h12;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_fe    = fe_cnt;
    for (int f = 0; f < 12; f++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad);
      rx = 1'b1;
      if (bad) begin
        m_fe++;
      end else begin
        if (m_valid) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = b;
      end
      check_model($sformatf("rnd%0d", f));
      gap = bad ? $urandom_range(2, 6) : $urandom_range(0, 6);
      if (gap > 0 && $urandom_range(0, 1) == 1) begin
        pulse_ack();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        gap--;
      end
      repeat (gap) tick();
    end

    // Ack landing on the same cycle a new byte completes
    pulse_ack();
    send_frame(8'hC3, 1'b1);
    fork
      send_frame(8'h96, 1'b1);
      begin
        repeat (97) @(posedge clock);
        #1 rxack = 1'b1;
        @(posedge clock);
        #1 rxack = 1'b0;
      end
    join
    chk("same_ack_data",  32'(rxdata),  32'h96);
    chk("same_ack_valid", 32'(rxvalid), 32'h1);
    chk("same_ack_ovr",   32'(overrun), 32'h0);
    pulse_ack();

    // Reset during data bit 4 of 0x77
    b = 8'h77;
    rx = 1'b0;
    hold_bit();
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      hold_bit();
    end
    rx = b[4];
    repeat (5) tick();
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) tick();
    chk("mid_rst_busy",  32'(busy),    32'h0);
    chk("mid_rst_valid", 32'(rxvalid), 32'h0);
    reset = 1'b1;
    repeat (120) tick();
    chk("mid_rst_quiet", 32'(rxvalid), 32'h0);
    chk("mid_rst_data0", 32'(rxdata),  32'h0);
    send_frame(8'h81, 1'b1);
    chk("mid_rst_81_valid", 32'(rxvalid), 32'h1);
    chk("mid_rst_81_data",  32'(rxdata),  32'h81);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
